// File: rtl/prog_loader.sv
// prog_loader: host-side writer for the core's instruction memory.
// Receives a halfword stream (length word, then high/low halves of each
// instruction) over valid/ready, writes each assembled instruction into
// instruction memory, then releases the core from reset.
//
// Optional feature macro: LOADER_CKSUM_EN
//   When defined, a trailing checksum halfword (XOR of all instruction
//   halfwords) must match before the core is released.
//
// Ports:
//   clk       system clock
//   sys_rst   asynchronous active-high reset
//   start     single-cycle pulse that begins a load (IDLE or DONE only)
//   in_valid  stream halfword valid
//   in_data   stream halfword
//   in_ready  loader accepts in_data this cycle (state-only, registered)
//   im_we     instruction memory write enable (one-cycle pulse)
//   im_addr   instruction memory write address
//   im_wdata  instruction memory write data
//   core_rst  hold core in reset (active-high)
//   busy      load in progress
//   done      last load completed successfully
//   err       last load aborted on error
module prog_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 32,
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [HALF_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so the count can hold DEPTH and the address can step past
  // the last entry without wrapping.
  localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_DONE, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_DONE
  } state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  addr;
  logic [HALF_W-1:0] hi_latch;
  logic              xfer;
`ifdef LOADER_CKSUM_EN
  logic [HALF_W-1:0] cksum;
`endif

  assign xfer = in_valid & in_ready;

  // Load sequencer; every output is registered.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      addr      <= '0;
      hi_latch  <= '0;
`ifdef LOADER_CKSUM_EN
      cksum     <= '0;
`endif
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer) begin
            // Only the low five bits carry the length.
            if (in_data[4:0] == 5'd0 || 32'(in_data[4:0]) > DEPTH) begin
              state    <= S_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state     <= S_HI;
              remaining <= CNT_W'(in_data[4:0]);
              addr      <= '0;
`ifdef LOADER_CKSUM_EN
              cksum     <= '0;
`endif
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_latch <= in_data;
            state    <= S_LO;
`ifdef LOADER_CKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
          end
        end
        S_LO: begin
          if (xfer) begin
            im_wdata <= {hi_latch, in_data};
            im_addr  <= addr[ADDR_W-1:0];
            im_we    <= 1'b1;
            in_ready <= 1'b0;
            state    <= S_WRITE;
`ifdef LOADER_CKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
          end
        end
        S_WRITE: begin
          addr      <= addr + CNT_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
`ifdef LOADER_CKSUM_EN
            state    <= S_CHK;
            in_ready <= 1'b1;
`else
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b0;
`endif
          end else begin
            state    <= S_HI;
            in_ready <= 1'b1;
          end
        end
`ifdef LOADER_CKSUM_EN
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == cksum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state    <= S_IDLE;
              err      <= 1'b1;
              core_rst <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, hand-written corner
// sequences, and randomized loads checked against a stream-level model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        im_we;
  logic [3:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] hs[$];      // halfwords the loader is expected to accept
  logic [35:0] exp_w[$];   // expected writes {addr, data}
  logic [35:0] got_w[$];   // observed writes {addr, data}
  bit          exp_done;

  typedef struct packed {
    logic [15:0]      len;
    logic [2:0][31:0] inst;
    logic [1:0]       n;
    logic             ok;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: records each write, checks pulse width and that no
  // halfword could be accepted in the write cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      got_w.push_back({im_addr, im_wdata});
      check("we_ready_low", 64'(in_ready), 64'(0));
      check("we_one_cycle", 64'(prev_we), 64'(0));
    end
    prev_we <= im_we;
  end

  function automatic vec_t mk(input logic [15:0] len, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [31:0] i2,
                              input logic [1:0] n, input logic ok);
    vec_t v;
    v.len  = len;
    v.inst = {i2, i1, i0};
    v.n    = n;
    v.ok   = ok;
    return v;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one halfword until accepted; in_valid optionally drops at random.
  task automatic send(input logic [15:0] d, input bit gaps);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready) begin
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          return;
        end
      end
      t++;
      if (t > 200) begin
        check("send_timeout", 64'(1), 64'(0));
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  // Reference: expected writes/outcome straight from the halfword stream.
  task automatic model();
    int cnt;
    logic [15:0] x;
    exp_w.delete();
    exp_done = 1'b0;
    cnt = int'(hs[0][4:0]);
    if (cnt < 1 || cnt > 16) return;
    x = 16'h0000;
    for (int i = 0; i < cnt; i++) begin
      exp_w.push_back({4'(i), hs[1+2*i], hs[2+2*i]});
      x = x ^ hs[1+2*i] ^ hs[2+2*i];
    end
`ifdef LOADER_CKSUM_EN
    exp_done = (hs[1+2*cnt] == x);
`else
    exp_done = 1'b1;
`endif
  endtask

  // Run one load of hs[] and compare against exp_w / exp_done.
  task automatic load(input string name, input bit gaps, input int start_at);
    bit settled;
    got_w.delete();
    pulse_start();
    check({name, "_start_busy"}, 64'(busy), 64'(1));
    check({name, "_start_corerst"}, 64'(core_rst), 64'(1));
    check({name, "_start_done"}, 64'(done), 64'(0));
    foreach (hs[i]) begin
      if (i == start_at) pulse_start();
      send(hs[i], gaps);
    end
    settled = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        settled = 1'b1;
        break;
      end
    end
    check({name, "_settled"}, 64'(settled), 64'(1));
    check({name, "_nwrites"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check({name, "_write"}, 64'(got_w[i]), 64'(exp_w[i]));
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"}, 64'(err), 64'(!exp_done));
    check({name, "_corerst"}, 64'(core_rst), 64'(!exp_done));
    check({name, "_ready"}, 64'(in_ready), 64'(0));
  endtask

  // Build stream and expectations from a table entry.
  task automatic from_vec(input vec_t v);
    logic [15:0] x;
    hs.delete();
    exp_w.delete();
    hs.push_back(v.len);
    x = 16'h0000;
    if (v.ok) begin
      for (int i = 0; i < int'(v.n); i++) begin
        hs.push_back(v.inst[i][31:16]);
        hs.push_back(v.inst[i][15:0]);
        x = x ^ v.inst[i][31:16] ^ v.inst[i][15:0];
        exp_w.push_back({4'(i), v.inst[i]});
      end
`ifdef LOADER_CKSUM_EN
      hs.push_back(x);
`endif
    end
    exp_done = v.ok;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 64'(in_ready), 64'(0));
    check({name, "_we"}, 64'(im_we), 64'(0));
    check({name, "_addr"}, 64'(im_addr), 64'(0));
    check({name, "_wdata"}, 64'(im_wdata), 64'(0));
    check({name, "_corerst"}, 64'(core_rst), 64'(1));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(16'h0003, 32'h08010005, 32'h10000002, 32'hC8000000, 2'd3, 1'b1);
    tbl[1] = mk(16'h0000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    tbl[2] = mk(16'h0011, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    tbl[3] = mk(16'hFFE1, 32'hDEADBEEF, 32'h0, 32'h0, 2'd1, 1'b1);
    tbl[4] = mk(16'h0002, 32'hA5A55A5A, 32'h0000FFFF, 32'h0, 2'd2, 1'b1);
    tbl[5] = mk(16'h0020, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);

    sys_rst  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    sys_rst = 1'b0;

    // Table vectors, back to back (later loads start from DONE or IDLE).
    foreach (tbl[i]) begin
      from_vec(tbl[i]);
      load($sformatf("vec%0d", i), 1'b0, -1);
    end

    // Basic load with random valid gaps.
    from_vec(tbl[0]);
    load("gaps", 1'b1, -1);

    // Start pulsed mid-load is ignored.
    from_vec(tbl[0]);
    load("midstart", 1'b0, 3);

    // Reset asserted mid-cycle after the second write.
    from_vec(tbl[0]);
    got_w.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send(hs[i], 1'b0);
    @(negedge clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    sys_rst  = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0002;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("abort_nwrites", 64'(got_w.size()), 64'(2));
    if (got_w.size() >= 2)
      check("abort_w1", 64'(got_w[1]), 64'({4'd1, 32'h10000002}));
    check("abort_done", 64'(done), 64'(0));
    check("abort_corerst", 64'(core_rst), 64'(1));

    // Full reload after abort.
    from_vec(tbl[0]);
    load("reload", 1'b0, -1);

`ifdef LOADER_CKSUM_EN
    hs = '{16'h0001, 16'h1234, 16'h00FF, 16'h12CB};
    exp_w = '{{4'd0, 32'h123400FF}};
    exp_done = 1'b1;
    load("cks_good", 1'b0, -1);
    hs = '{16'h0001, 16'h1234, 16'h00FF, 16'h0000};
    exp_w = '{{4'd0, 32'h123400FF}};
    exp_done = 1'b0;
    load("cks_bad", 1'b0, -1);
`endif

    // Randomized loads against the stream model.
    for (int r = 0; r < 25; r++) begin
      int cnt;
      logic [15:0] x;
      cnt = (r == 0) ? 16 : int'($urandom_range(0, 18));
      hs.delete();
      hs.push_back({11'($urandom), 5'(cnt)});
      x = 16'h0000;
      if (cnt >= 1 && cnt <= 16) begin
        for (int i = 0; i < 2 * cnt; i++) begin
          hs.push_back(16'($urandom));
          x = x ^ hs[hs.size()-1];
        end
`ifdef LOADER_CKSUM_EN
        if ($urandom_range(0, 3) == 0)
          hs.push_back(x ^ 16'($urandom_range(1, 65535)));
        else
          hs.push_back(x);
`endif
      end
      model();
      load($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
